// File: rtl/gtrg_rdseq.sv
// Read-side sequencer for the global-trigger DAV/BX FIFO: latches one event, pops it
// exactly once, then services each flagged readout device in index order with a timeout.
module gtrg_rdseq #(
  parameter int TMR   = 0,
  parameter int TMO_W = 8,
  parameter int TMO   = 200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EMPTY_B,
  input  logic [16:0] DAVSOUT,
  input  logic [11:0] BXCOUNTOUT,
  input  logic [3:0]  CFEBBX,
  input  logic        STOP,
  input  logic [6:0]  DEVDONE,
  output logic        POP,
  output logic [6:0]  DEVREQ,
  output logic [16:0] EVT_DAV,
  output logic [11:0] EVT_BX,
  output logic [3:0]  EVT_CFEBBX,
  output logic [4:0]  EVT_MISMATCH,
  output logic [6:0]  TOERR,
  output logic        EVT_DONE,
  output logic        BUSY,
  output logic [15:0] EVTCNT,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LATCH = 3'd2,
    S_SCAN  = 3'd3,
    S_REQ   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO - 1);
  localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

  // Device handshake: DEVREQ[k] is a level request held until the edge that samples
  // DEVDONE[k]=1 (or the timeout fires) and drops on that edge; other DEVDONE bits are ignored.

  state_t        state_q, state_d;
  logic [6:0]    pending_q, pending_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]    cur_q, cur_d;
  logic          pop_q, pop_d;
  logic [6:0]    devreq_q, devreq_d;
  logic [16:0]   evt_dav_q, evt_dav_d;
  logic [11:0]   evt_bx_q, evt_bx_d;
  logic [3:0]    evt_cfebbx_q, evt_cfebbx_d;
  logic [4:0]    evt_mismatch_q, evt_mismatch_d;
  logic [6:0]    toerr_q, toerr_d;
  logic          evt_done_q, evt_done_d;
  logic          busy_q, busy_d;
  logic [15:0]   evtcnt_q, evtcnt_d;
  logic [2:0]    sel_idx;

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 3'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    cnt_d          = cnt_q;
    cur_d          = cur_q;
    pop_d          = 1'b0;
    devreq_d       = devreq_q;
    evt_dav_d      = evt_dav_q;
    evt_bx_d       = evt_bx_q;
    evt_cfebbx_d   = evt_cfebbx_q;
    evt_mismatch_d = evt_mismatch_q;
    toerr_d        = toerr_q;
    evt_done_d     = 1'b0;
    evtcnt_d       = evtcnt_q;
    case (state_q)
      S_IDLE: begin
        if (EMPTY_B && !STOP) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!EMPTY_B) begin
          state_d = S_IDLE;
        end else begin
          state_d        = S_LATCH;
          pop_d          = 1'b1;
          evt_dav_d      = DAVSOUT;
          evt_bx_d       = BXCOUNTOUT;
          evt_cfebbx_d   = CFEBBX;
          evt_mismatch_d = (DAVSOUT[5:1] | DAVSOUT[10:6]) ^ DAVSOUT[15:11];
          pending_d      = {DAVSOUT[16], DAVSOUT[5:1], DAVSOUT[0]};
          toerr_d        = '0;
        end
      end
      S_LATCH: begin
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (pending_q == 7'd0) begin
          state_d    = S_DONE;
          evt_done_d = 1'b1;
          evtcnt_d   = evtcnt_q + 16'd1;
        end else begin
          state_d            = S_REQ;
          pending_d[sel_idx] = 1'b0;
          cnt_d              = '0;
          cur_d              = sel_idx;
          devreq_d           = 7'd1 << sel_idx;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_ONE;
        // A done arriving on the timeout cycle wins, so no error is flagged then.
        if (DEVDONE[cur_q]) begin
          state_d  = S_SCAN;
          devreq_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = S_SCAN;
          devreq_d       = '0;
          toerr_d[cur_q] = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        devreq_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  generate
    if (TMR != 0) begin : g_tmr
      state_t state_a_q, state_b_q, state_c_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_a_q <= S_IDLE;
          state_b_q <= S_IDLE;
          state_c_q <= S_IDLE;
        end else begin
          state_a_q <= state_d;
          state_b_q <= state_d;
          state_c_q <= state_d;
        end
      end
      assign state_q = state_t'((state_a_q & state_b_q) | (state_a_q & state_c_q) |
                                (state_b_q & state_c_q));
    end else begin : g_single
      state_t state_s_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_s_q <= S_IDLE;
        else     state_s_q <= state_d;
      end
      assign state_q = state_s_q;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q      <= '0;
      cnt_q          <= '0;
      cur_q          <= '0;
      pop_q          <= 1'b0;
      devreq_q       <= '0;
      evt_dav_q      <= '0;
      evt_bx_q       <= '0;
      evt_cfebbx_q   <= '0;
      evt_mismatch_q <= '0;
      toerr_q        <= '0;
      evt_done_q     <= 1'b0;
      busy_q         <= 1'b0;
      evtcnt_q       <= '0;
    end else begin
      pending_q      <= pending_d;
      cnt_q          <= cnt_d;
      cur_q          <= cur_d;
      pop_q          <= pop_d;
      devreq_q       <= devreq_d;
      evt_dav_q      <= evt_dav_d;
      evt_bx_q       <= evt_bx_d;
      evt_cfebbx_q   <= evt_cfebbx_d;
      evt_mismatch_q <= evt_mismatch_d;
      toerr_q        <= toerr_d;
      evt_done_q     <= evt_done_d;
      busy_q         <= busy_d;
      evtcnt_q       <= evtcnt_d;
    end
  end

  // Gate with EMPTY_B so a pop can never reach an empty FIFO.
  assign POP          = pop_q & EMPTY_B;
  assign DEVREQ       = devreq_q;
  assign EVT_DAV      = evt_dav_q;
  assign EVT_BX       = evt_bx_q;
  assign EVT_CFEBBX   = evt_cfebbx_q;
  assign EVT_MISMATCH = evt_mismatch_q;
  assign TOERR        = toerr_q;
  assign EVT_DONE     = evt_done_q;
  assign BUSY         = busy_q;
  assign EVTCNT       = evtcnt_q;
  assign DBG_STATE    = state_q;

endmodule
